switch_keyboard_tx: RTL and testbench

Parametrised switch keyboard with integrated buffered UART transmitter. On each debounced button press it samples the 4 switches, maps the code to an ASCII character and queues it in a small FIFO. An 8N1 transmitter drains the FIFO onto the serial line. Sits between board switches/button and the host UART link, replacing the single-shot keyboard path.

---
 rtl/switch_keyboard_tx_if.sv | 42 ++++
 rtl/switch_keyboard_tx.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_switch_keyboard_tx.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_keyboard_tx_if.sv
// -----------------------------------------------------------------------------
// switch_keyboard_tx_if
//
// Purpose : Bundles the board-side inputs (switches, push button) and the
//           UART/status outputs of switch_keyboard_tx into one port.
//
// Signals :
//   sw         [3:0]                    switch code, sw[0] = LSB (asynchronous)
//   btn                                 raw push button, active-high (asynchronous)
//   tx                                  UART serial out, idle high
//   busy                                high while a frame is on the line
//   fifo_level [$clog2(FIFO_DEPTH):0]   entries currently queued
//   invalid                             one-cycle pulse: press with unmapped code
//   overflow                            one-cycle pulse: press dropped, queue full
//
// Modports:
//   master : board/host side, drives sw/btn and observes the outputs
//   slave  : the keyboard transmitter itself
// -----------------------------------------------------------------------------
interface switch_keyboard_tx_if #(
   parameter int FIFO_DEPTH = 4
);

   logic [3:0]                  sw;
   logic                        btn;
   logic                        tx;
   logic                        busy;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
   logic                        invalid;
   logic                        overflow;

   modport master (
      output sw, btn,
      input  tx, busy, fifo_level, invalid, overflow
   );

   modport slave (
      input  sw, btn,
      output tx, busy, fifo_level, invalid, overflow
   );

endinterface : switch_keyboard_tx_if

// File: rtl/switch_keyboard_tx.sv
// -----------------------------------------------------------------------------
// switch_keyboard_tx
//
// Purpose : Switch keyboard with a buffered 8N1 UART transmitter. Every
//           debounced press of the button samples the four switches, maps the
//           code to an ASCII character and queues it in a small FIFO. The
//           transmitter drains the FIFO onto the serial line, LSB first.
//
// Parameters:
//   CLKS_PER_BIT : sysclk cycles per UART bit (>= 2)
//   DEB_CYCLES   : consecutive stable cycles to accept a button change (>= 1)
//   FIFO_DEPTH   : character queue entries (power of 2, >= 2)
//   HEX_MODE     : 0 = digits plus 'u' on 1111, 1 = full hex 0-9,A-F
//
// Ports:
//   sysclk : system clock, all logic on the rising edge
//   rst_n  : asynchronous active-low reset (released synchronously inside)
//   bus    : switch_keyboard_tx_if.slave (sw, btn in; tx, busy, fifo_level,
//            invalid, overflow out)
//
// Timing from a press, with an empty queue and an idle transmitter:
//   edge E   : debounced state rises, press pulse registered
//   edge E+1 : character written into the FIFO
//   edge E+2 : character popped, tx drops for the start bit
// -----------------------------------------------------------------------------
module switch_keyboard_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEB_CYCLES   = 1000000,
   parameter int FIFO_DEPTH   = 4,
   parameter int HEX_MODE     = 0
) (
   input logic                 sysclk,
   input logic                 rst_n,
   switch_keyboard_tx_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int DW = $clog2(DEB_CYCLES + 1);

   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // ---------------------------------------------------------------------------
   // Reset synchroniser: assertion takes effect at once, release is aligned to
   // sysclk so no flop sees reset removal near its clock edge.
   // ---------------------------------------------------------------------------
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   // NOTE: sequential state is always written with <= so every flop samples
   // the pre-edge values of its neighbours regardless of block ordering.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   // ---------------------------------------------------------------------------
   // Input synchronisers for the asynchronous button and switches
   // ---------------------------------------------------------------------------
   logic       r_btn_meta;
   logic       r_btn_sync;
   logic [3:0] r_sw_meta;
   logic [3:0] r_sw_sync;

   always_ff @(posedge sysclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_btn_meta <= 1'b0;
         r_btn_sync <= 1'b0;
         r_sw_meta  <= 4'h0;
         r_sw_sync  <= 4'h0;
      end else begin
         r_btn_meta <= bus.btn;
         r_btn_sync <= r_btn_meta;
         r_sw_meta  <= bus.sw;
         r_sw_sync  <= r_sw_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Debounce and press detection. The counter only runs while the synced
   // button disagrees with the accepted state, so any bounce back to the
   // accepted level restarts the qualification window. r_press is high for
   // the single cycle after the accepted state rises.
   // ---------------------------------------------------------------------------
   logic [DW-1:0] r_deb_cnt;
   logic          r_btn_deb;
   logic          r_press;

   always_ff @(posedge sysclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_deb_cnt <= '0;
         r_btn_deb <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_press <= 1'b0;
         if (r_btn_sync != r_btn_deb) begin
            if (r_deb_cnt == DEB_LAST) begin
               r_deb_cnt <= '0;
               r_btn_deb <= ~r_btn_deb;
               r_press   <= ~r_btn_deb;
            end else begin
               r_deb_cnt <= r_deb_cnt + DW'(1);
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Switch code to ASCII
   // ---------------------------------------------------------------------------
   logic [7:0] w_char;
   logic       w_mapped;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_char   = 8'h00;
      w_mapped = 1'b0;
      if (r_sw_sync <= 4'd9) begin
         w_char   = 8'h30 + {4'h0, r_sw_sync};
         w_mapped = 1'b1;
      end else if (HEX_MODE != 0) begin
         // 0x37 + 10 = 'A'
         w_char   = 8'h37 + {4'h0, r_sw_sync};
         w_mapped = 1'b1;
      end else if (r_sw_sync == 4'hF) begin
         w_char   = 8'h75;
         w_mapped = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Character FIFO. Pointers carry one extra wrap bit so full and empty are
   // told apart by comparing pointers alone. A press into a full queue is still
   // accepted when the transmitter pops in the same cycle.
   // ---------------------------------------------------------------------------
   state_t      r_state;
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic [7:0]  r_mem [FIFO_DEPTH];
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push;
   logic        r_invalid;
   logic        r_overflow;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop   = (r_state == IDLE) && !w_empty;
   assign w_push  = r_press && w_mapped && (!w_full || w_pop);

   // NOTE: the storage array has no reset; the pointers define which entries
   // are valid, so clearing the data would only cost reset routing.
   always_ff @(posedge sysclk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= w_char;
      end
   end

   always_ff @(posedge sysclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_invalid  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + (AW+1)'(1);
         end
         r_invalid  <= r_press && !w_mapped;
         r_overflow <= r_press && w_mapped && w_full && !w_pop;
      end
   end

   // ---------------------------------------------------------------------------
   // 8N1 transmitter. tx is registered and always reflects the bit currently
   // on the line; r_shift holds the remaining data bits with the active one in
   // bit 0. Leaving STOP costs one IDLE cycle before the next pop, which gives
   // a single extra high cycle between back-to-back frames.
   // ---------------------------------------------------------------------------
   logic [CW-1:0] r_clk_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_busy;

   always_ff @(posedge sysclk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx      <= 1'b1;
               r_busy    <= 1'b0;
               r_clk_cnt <= '0;
               if (w_pop) begin
                  r_shift <= r_mem[r_rptr[AW-1:0]];
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= START;
               end
            end

            START: begin
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt <= '0;
                  r_bit_idx <= 3'd0;
                  r_tx      <= r_shift[0];
                  r_state   <= DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end

            DATA: begin
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end

            STOP: begin
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt <= '0;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end

            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.tx         = r_tx;
   assign bus.busy       = r_busy;
   assign bus.fifo_level = r_wptr - r_rptr;
   assign bus.invalid    = r_invalid;
   assign bus.overflow   = r_overflow;

endmodule : switch_keyboard_tx

// File: tb/tb_switch_keyboard_tx.sv
// -----------------------------------------------------------------------------
// tb_switch_keyboard_tx
//
// Two instances share the same stimulus: u_dut0 with HEX_MODE=0 and u_dut1
// with HEX_MODE=1 (CLKS_PER_BIT=4, DEB_CYCLES=3, FIFO_DEPTH=2). Inputs are
// driven and outputs sampled 1 time unit after each rising edge. With a clean
// press set just after edge P0, the debounced state rises at P5, the
// character is written at P6 and tx falls at P7 (the 7th sample).
// -----------------------------------------------------------------------------
module tb_switch_keyboard_tx;

   localparam int CPB   = 4;
   localparam int DEB   = 3;
   localparam int DEPTH = 2;

   logic       sysclk;
   logic       rst_n;
   logic [3:0] sw;
   logic       btn;

   int n_checks = 0;
   int n_errs   = 0;

   switch_keyboard_tx_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
   switch_keyboard_tx_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

   assign bus0.sw  = sw;
   assign bus0.btn = btn;
   assign bus1.sw  = sw;
   assign bus1.btn = btn;

   switch_keyboard_tx #(
      .CLKS_PER_BIT(CPB), .DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .HEX_MODE(0)
   ) u_dut0 (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   switch_keyboard_tx #(
      .CLKS_PER_BIT(CPB), .DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .HEX_MODE(1)
   ) u_dut1 (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // Pulse and level monitors, sampled on the falling edge
   int ovf0_cnt = 0;
   int inv0_cnt = 0;
   int inv1_cnt = 0;
   int max_lvl  = 0;

   always @(negedge sysclk) begin
      if (bus0.overflow === 1'b1) ovf0_cnt <= ovf0_cnt + 1;
      if (bus0.invalid === 1'b1)  inv0_cnt <= inv0_cnt + 1;
      if (bus1.invalid === 1'b1)  inv1_cnt <= inv1_cnt + 1;
      if (int'(bus0.fifo_level) > max_lvl) max_lvl <= int'(bus0.fifo_level);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   // Expected line level for cycle c of a frame carrying ch
   function automatic logic exp_bit(input logic [7:0] ch, input int c);
      int b;
      b = c / CPB;
      if (b == 0)      return 1'b0;
      else if (b <= 8) return ch[b-1];
      else             return 1'b1;
   endfunction

   // Called on the first start-bit cycle; walks the 40 frame cycles and leaves
   // the bench on the first cycle after the stop bit. A disabled instance
   // must stay idle throughout.
   task automatic frame(input string tag, input logic en0, input logic [7:0] c0,
                        input logic en1, input logic [7:0] c1);
      int         bad;
      int         busy_cyc;
      int         b;
      logic [7:0] got0;
      logic [7:0] got1;
      bad = 0; busy_cyc = 0; got0 = 8'h00; got1 = 8'h00;
      for (int c = 0; c < 10*CPB; c++) begin
         b = c / CPB;
         if (en0) begin
            if (bus0.tx !== exp_bit(c0, c) || bus0.busy !== 1'b1) bad++;
         end else if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0) bad++;
         if (en1) begin
            if (bus1.tx !== exp_bit(c1, c) || bus1.busy !== 1'b1) bad++;
         end else if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0) bad++;
         if (bus0.busy === 1'b1) busy_cyc++;
         if ((c % CPB) == CPB/2 && b >= 1 && b <= 8) begin
            got0[b-1] = bus0.tx;
            got1[b-1] = bus1.tx;
         end
         tick();
      end
      check({tag, "_wave_errs"}, bad, 0);
      if (en0) check({tag, "_byte0"}, got0, c0);
      if (en1) check({tag, "_byte1"}, got1, c1);
      check({tag, "_busy_cycles"}, busy_cyc, en0 ? 10*CPB : 0);
   endtask

   // Between back-to-back frames: exactly one idle cycle, then a start bit
   task automatic gap(input string tag);
      check({tag, "_idle_tx_busy"}, {bus0.tx, bus0.busy}, 2'b10);
      tick();
      check({tag, "_next_start"}, bus0.tx, 1'b0);
   endtask

   // Press and hold; returns after the 6th sample (edge E+1)
   task automatic start_press(input logic [3:0] code, output int early_lows,
                              output logic inv_at6, output int lvl_at6);
      sw = code; btn = 1'b1;
      early_lows = 0; inv_at6 = 1'b0; lvl_at6 = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (bus0.tx !== 1'b1 || bus1.tx !== 1'b1) early_lows++;
         if (i == 6) begin
            inv_at6 = bus0.invalid;
            lvl_at6 = int'(bus0.fifo_level);
         end
      end
   endtask

   // Clean press: 5 cycles high, 5 cycles low
   task automatic tap(input logic [3:0] code);
      sw = code; btn = 1'b1;
      repeat (5) tick();
      btn = 1'b0;
      repeat (5) tick();
   endtask

   task automatic quiet(input string tag, input int n);
      int lows;
      lows = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus0.tx !== 1'b1 || bus1.tx !== 1'b1 || bus0.busy !== 1'b0) lows++;
      end
      check({tag, "_line_idle"}, lows, 0);
      check({tag, "_level"}, bus0.fifo_level, 0);
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      int   lows;
      logic inv6;
      int   lvl6;
      int   ovf_snap;
      int   inv0_snap;
      int   inv1_snap;

      rst_n = 1'b0; sw = 4'h0; btn = 1'b0;
      repeat (3) tick();
      check("reset_outs0", {bus0.tx, bus0.busy, bus0.fifo_level, bus0.invalid, bus0.overflow}, 6'b100000);
      check("reset_outs1", {bus1.tx, bus1.busy, bus1.fifo_level, bus1.invalid, bus1.overflow}, 6'b100000);
      rst_n = 1'b1;
      repeat (5) tick();

      // 1: clean press of 0101 -> '5', latency and frame shape
      start_press(4'b0101, lows, inv6, lvl6);
      check("t1_no_early_start", lows, 0);
      check("t1_level_at_E+1", lvl6, 1);
      tick();
      check("t1_fall_at_E+2", bus0.tx, 1'b0);
      check("t1_level_after_pop", bus0.fifo_level, 0);
      frame("t1", 1'b1, 8'h35, 1'b1, 8'h35);
      check("t1_idle_after", {bus0.tx, bus0.busy}, 2'b10);
      quiet("t1_held", 20);
      btn = 1'b0;
      quiet("t1_release", 10);

      // 2: bouncing button, then held -> exactly one '0'
      sw = 4'h0;
      for (int k = 0; k < 5; k++) begin
         btn = 1'b1; repeat (2) tick();
         btn = 1'b0; repeat (2) tick();
      end
      check("t2_bounce_level", bus0.fifo_level, 0);
      check("t2_bounce_busy", bus0.busy, 1'b0);
      start_press(4'h0, lows, inv6, lvl6);
      check("t2_no_early_start", lows, 0);
      tick();
      check("t2_fall_at_E+2", bus0.tx, 1'b0);
      frame("t2", 1'b1, 8'h30, 1'b1, 8'h30);
      btn = 1'b0;
      quiet("t2_after", 10);

      // 3: mode-dependent mapping
      start_press(4'hF, lows, inv6, lvl6);
      tick();
      frame("t3_1111", 1'b1, 8'h75, 1'b1, 8'h46);
      btn = 1'b0;
      repeat (10) tick();

      inv0_snap = inv0_cnt; inv1_snap = inv1_cnt;
      start_press(4'hC, lows, inv6, lvl6);
      check("t3_invalid_at_E+1", inv6, 1'b1);
      check("t3_no_push", lvl6, 0);
      tick();
      check("t3_invalid_one_cycle", bus0.invalid, 1'b0);
      check("t3_hex_fall", bus1.tx, 1'b0);
      frame("t3_1100", 1'b0, 8'h00, 1'b1, 8'h43);
      check("t3_invalid_count0", inv0_cnt - inv0_snap, 1);
      check("t3_invalid_count1", inv1_cnt - inv1_snap, 0);
      btn = 1'b0;
      quiet("t3_after", 10);

      // 4: four presses during the first frame -> 3 frames, 1 overflow
      ovf_snap = ovf0_cnt;
      fork
         begin
            for (int k = 1; k <= 4; k++) tap(4'(k));
         end
         begin
            repeat (7) tick();
            check("t4_fall", bus0.tx, 1'b0);
            frame("t4_a", 1'b1, 8'h31, 1'b1, 8'h31);
            gap("t4_gap1");
            frame("t4_b", 1'b1, 8'h32, 1'b1, 8'h32);
            gap("t4_gap2");
            frame("t4_c", 1'b1, 8'h33, 1'b1, 8'h33);
         end
      join
      quiet("t4_after", 20);
      check("t4_overflow_count", ovf0_cnt - ovf_snap, 1);
      check("t4_max_level", max_lvl, DEPTH);

      // 6: press landing in the IDLE pop cycle with a full queue
      ovf_snap = ovf0_cnt;
      fork
         begin
            tap(4'h6);
            tap(4'h7);
            tap(4'h8);
            repeat (12) tick();
            sw = 4'h9; btn = 1'b1;
            repeat (5) tick();
            check("t6_full_before_pop", bus0.fifo_level, 2);
            check("t6_idle_cycle", bus0.busy, 1'b0);
            tick();
            check("t6_level_after_push_pop", bus0.fifo_level, 2);
            btn = 1'b0;
            repeat (5) tick();
         end
         begin
            repeat (7) tick();
            check("t6_fall", bus0.tx, 1'b0);
            frame("t6_a", 1'b1, 8'h36, 1'b1, 8'h36);
            gap("t6_gap1");
            frame("t6_b", 1'b1, 8'h37, 1'b1, 8'h37);
            gap("t6_gap2");
            frame("t6_c", 1'b1, 8'h38, 1'b1, 8'h38);
            gap("t6_gap3");
            frame("t6_d", 1'b1, 8'h39, 1'b1, 8'h39);
         end
      join
      check("t6_no_overflow", ovf0_cnt - ovf_snap, 0);
      quiet("t6_after", 10);

      // 5: reset in the middle of '9' with '1' queued
      tap(4'h9);
      tap(4'h1);
      repeat (10) tick();
      check("t5_pre_reset_busy", bus0.busy, 1'b1);
      check("t5_pre_reset_level", bus0.fifo_level, 1);
      rst_n = 1'b0;
      #1;
      check("t5_reset_outs0", {bus0.tx, bus0.busy, bus0.fifo_level}, 4'b1000);
      check("t5_reset_outs1", {bus1.tx, bus1.busy, bus1.fifo_level}, 4'b1000);
      repeat (3) tick();
      rst_n = 1'b1;
      quiet("t5_after_release", 60);
      start_press(4'h2, lows, inv6, lvl6);
      check("t5_no_early_start", lows, 0);
      tick();
      check("t5_new_fall", bus0.tx, 1'b0);
      frame("t5_new", 1'b1, 8'h32, 1'b1, 8'h32);
      btn = 1'b0;
      quiet("t5_end", 10);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule : tb_switch_keyboard_tx
